credit_loop_controller_mc: RTL and testbench
============================================

Name: credit_loop_controller_mc

Overview:
- Parametrised, multi-channel successor of the sideband RDI credit loop controller.
- Each channel has two independent halves:
  - Credit notifier: returns one credit to the adapter for each TX FIFO read, via a per-credit pulse on o_pl_cfg_crd.
  - Credit counter: tracks credits available at the adapter. Consumed on each pl_cfg_vld rising edge, replenished on each lp_cfg_crd, flags full at zero.
- Added over the single-channel block: notify stall with a pending queue, programmable initial credits, sticky overflow/underflow errors, and a readable credit count.

Parameters:
- NUM_CH, 2, number of independent credit channels.
- MAX_CREDITS, 32, maximum credits per channel. Upper bound for both the available counter and the pending-return counter.
- INIT_CREDITS, 32, available credits loaded at reset. Must be <= MAX_CREDITS.
- CREDIT_W, $clog2(MAX_CREDITS+1), width of each counter (6 at default).

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst  in  1  synchronous active-high reset.
- i_tx_fifo_read_en  in  NUM_CH  per-channel TX FIFO read strobe; 1 cycle = 1 credit to return.
- i_crd_hold  in  NUM_CH  per-channel notify stall; while high no o_pl_cfg_crd pulses issue.
- o_pl_cfg_crd  out  NUM_CH  per-channel credit return; each high cycle = 1 credit.
- i_lp_cfg_crd  in  NUM_CH  per-channel credit received from the adapter; +1 per high cycle.
- i_rising_edge_pl_cfg_vld  in  NUM_CH  per-channel message sent; -1 credit per high cycle.
- o_adapter_is_full  out  NUM_CH  per-channel, high when available credits == 0.
- o_avail_credits  out  NUM_CH*CREDIT_W  available count; channel c occupies bits [c*CREDIT_W +: CREDIT_W].
- o_pending_credits  out  NUM_CH*CREDIT_W  pending-return count, same packing.
- i_err_clr  in  1  clears all sticky error flags.
- o_ovf_err  out  NUM_CH  sticky, set on counter overflow attempt.
- o_udf_err  out  NUM_CH  sticky, set on consume with zero credits.

Behaviour:
- Channels are fully independent; there are no shared resources between them.
- Reset (i_rst sampled high), per channel:
  - avail = INIT_CREDITS; pending = 0.
  - o_pl_cfg_crd = 0; o_ovf_err = 0; o_udf_err = 0.
  - o_adapter_is_full = (INIT_CREDITS == 0).
  - Reset mid-operation discards pending credits and any in-flight pulse; the first post-reset pulse is possible the cycle after reset deasserts.
- Notifier, per channel, with P = pending:
  - issue = !hold & (P != 0 | read_en).
  - o_pl_cfg_crd <= issue (registered).
  - P <= P + read_en - issue.
  - Latency: read_en in cycle N with P=0 and hold=0 gives a pulse in N+1, and P stays 0 (bypass).
  - Back-to-back read_en gives o_pl_cfg_crd continuously high, one credit per cycle.
  - Hold high: P accumulates. On hold release, P drains at 1 per cycle, so the pulse train length equals P.
  - If read_en arrives with P == MAX_CREDITS and issue == 0: P saturates and ovf_err is set.
- Counter, per channel, with A = avail:
  - inc = lp_cfg_crd; dec = rising_edge_pl_cfg_vld.
  - inc & dec: A unchanged.
  - inc only: if A == MAX_CREDITS, hold A and set ovf_err; else A+1.
  - dec only: if A == 0, hold A at 0 and set udf_err; else A-1.
  - Updates are registered, and o_avail_credits reflects them 1 cycle after the event.
  - o_adapter_is_full = (A == 0), decoded from the registered A, so it rises the same cycle A becomes 0.
- Errors:
  - Sticky until i_err_clr.
  - If i_err_clr and a new error event coincide, the flag stays set (set wins).
- Counters never wrap in either direction.

Test Plan:
- Reset, NUM_CH=2, INIT=32 -> avail={32,32}, full=00, pending=0, all errors 0. With INIT_CREDITS=0 build, full=11.
- Ch0: 4 isolated read_en pulses (1 high, 2 low), hold=0 -> 4 single-cycle o_pl_cfg_crd[0] pulses, each 1 cycle after its read_en. Ch1 pulses stay 0.
- Ch0: hold=1, 5 consecutive read_en -> pending=5, no pulses. Release hold -> o_pl_cfg_crd[0] high exactly 5 consecutive cycles, then pending=0.
- Ch1 from 32: 32 consume strobes -> avail=0 and full[1]=1. One more consume -> avail stays 0, udf_err[1]=1. Then 1 lp_cfg_crd -> avail=1, full=0. Then i_err_clr -> udf_err=0.
- Ch0 at avail=32: lp_cfg_crd and consume in the same cycle -> avail=32, no error. lp_cfg_crd alone -> avail=32, ovf_err[0]=1.
- Concurrency: 10 read_en every 4 cycles, 5 consumes every 6 cycles, one lp_cfg_crd at cycle 10 -> 10 total credit pulses. Final avail = INIT - 5 + 1 = 28, no errors. Assert o_avail_credits <= MAX_CREDITS every cycle.

Source files
------------

// File: rtl/credit_loop_if.sv
// Per-channel credit-loop signal bundle between the adapter side (master) and the
// credit loop controller (slave). Channel c of a packed count sits at [c*CREDIT_W +: CREDIT_W].
interface credit_loop_if #(
    parameter int NUM_CH   = 2,
    parameter int CREDIT_W = 6
);
    logic [NUM_CH-1:0]          i_tx_fifo_read_en;
    logic [NUM_CH-1:0]          i_crd_hold;
    logic [NUM_CH-1:0]          o_pl_cfg_crd;
    logic [NUM_CH-1:0]          i_lp_cfg_crd;
    logic [NUM_CH-1:0]          i_rising_edge_pl_cfg_vld;
    logic [NUM_CH-1:0]          o_adapter_is_full;
    logic [NUM_CH*CREDIT_W-1:0] o_avail_credits;
    logic [NUM_CH*CREDIT_W-1:0] o_pending_credits;
    logic                       i_err_clr;
    logic [NUM_CH-1:0]          o_ovf_err;
    logic [NUM_CH-1:0]          o_udf_err;

    modport master (
        output i_tx_fifo_read_en, i_crd_hold, i_lp_cfg_crd, i_rising_edge_pl_cfg_vld, i_err_clr,
        input  o_pl_cfg_crd, o_adapter_is_full, o_avail_credits, o_pending_credits,
               o_ovf_err, o_udf_err
    );

    modport slave (
        input  i_tx_fifo_read_en, i_crd_hold, i_lp_cfg_crd, i_rising_edge_pl_cfg_vld, i_err_clr,
        output o_pl_cfg_crd, o_adapter_is_full, o_avail_credits, o_pending_credits,
               o_ovf_err, o_udf_err
    );
endinterface

// File: rtl/credit_loop_controller_mc.sv
// Multi-channel credit loop controller: per channel, a credit notifier (return pulses with a
// hold-able pending queue) and a saturating available-credit counter, plus sticky error flags.
module credit_loop_controller_mc #(
    parameter int NUM_CH       = 2,
    parameter int MAX_CREDITS  = 32,
    parameter int INIT_CREDITS = 32,
    parameter int CREDIT_W     = $clog2(MAX_CREDITS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    credit_loop_if.slave  bus
);
    localparam logic [CREDIT_W-1:0] MAX_C  = CREDIT_W'(MAX_CREDITS);
    localparam logic [CREDIT_W-1:0] INIT_C = CREDIT_W'(INIT_CREDITS);
    localparam logic [CREDIT_W-1:0] ONE_C  = CREDIT_W'(1);

    logic [CREDIT_W-1:0] avail_q [NUM_CH];
    logic [CREDIT_W-1:0] avail_d [NUM_CH];
    logic [CREDIT_W-1:0] pend_q  [NUM_CH];
    logic [CREDIT_W-1:0] pend_d  [NUM_CH];
    logic [NUM_CH-1:0]   crd_q, crd_d;
    logic [NUM_CH-1:0]   ovf_q, ovf_d;
    logic [NUM_CH-1:0]   udf_q, udf_d;
    logic [NUM_CH-1:0]   issue, ovf_set, udf_set;

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        crd_d   = '0;
        issue   = '0;
        ovf_set = '0;
        udf_set = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            avail_d[c] = avail_q[c];
            pend_d[c]  = pend_q[c];
        end

        for (int c = 0; c < NUM_CH; c++) begin
            // A read with nothing queued and no hold bypasses the pending counter.
            issue[c] = !bus.i_crd_hold[c] && ((pend_q[c] != '0) || bus.i_tx_fifo_read_en[c]);
            crd_d[c] = issue[c];
            if (bus.i_tx_fifo_read_en[c] && !issue[c]) begin
                if (pend_q[c] == MAX_C) ovf_set[c] = 1'b1;
                else                    pend_d[c] = pend_q[c] + ONE_C;
            end else if (!bus.i_tx_fifo_read_en[c] && issue[c]) begin
                pend_d[c] = pend_q[c] - ONE_C;
            end

            // Simultaneous replenish and consume cancel out, even at the limits.
            if (bus.i_lp_cfg_crd[c] && !bus.i_rising_edge_pl_cfg_vld[c]) begin
                if (avail_q[c] == MAX_C) ovf_set[c] = 1'b1;
                else                     avail_d[c] = avail_q[c] + ONE_C;
            end else if (!bus.i_lp_cfg_crd[c] && bus.i_rising_edge_pl_cfg_vld[c]) begin
                if (avail_q[c] == '0) udf_set[c] = 1'b1;
                else                  avail_d[c] = avail_q[c] - ONE_C;
            end
        end

        // A new error event wins over a coincident clear.
        ovf_d = (ovf_q & ~{NUM_CH{bus.i_err_clr}}) | ovf_set;
        udf_d = (udf_q & ~{NUM_CH{bus.i_err_clr}}) | udf_set;
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (i_rst) begin
            crd_q <= '0;
            ovf_q <= '0;
            udf_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                avail_q[c] <= INIT_C;
                pend_q[c]  <= '0;
            end
        end else begin
            crd_q <= crd_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
            for (int c = 0; c < NUM_CH; c++) begin
                avail_q[c] <= avail_d[c];
                pend_q[c]  <= pend_d[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign bus.o_avail_credits[c*CREDIT_W +: CREDIT_W]   = avail_q[c];
        assign bus.o_pending_credits[c*CREDIT_W +: CREDIT_W] = pend_q[c];
        assign bus.o_adapter_is_full[c]                      = (avail_q[c] == '0);
    end

    assign bus.o_pl_cfg_crd = crd_q;
    assign bus.o_ovf_err    = ovf_q;
    assign bus.o_udf_err    = udf_q;
endmodule

// File: tb/tb_credit_loop_controller_mc.sv
// Directed bench for credit_loop_controller_mc: expected return pulses are queued when a read
// is driven and popped when the DUT pulses; counts and error flags follow a reference model.
module tb_credit_loop_controller_mc;
    localparam int NUM_CH       = 2;
    localparam int MAX_CREDITS  = 32;
    localparam int INIT_CREDITS = 32;
    localparam int CREDIT_W     = 6;

    logic i_clk = 1'b0;
    logic i_rst;

    credit_loop_if #(.NUM_CH(NUM_CH), .CREDIT_W(CREDIT_W)) bus ();
    credit_loop_if #(.NUM_CH(NUM_CH), .CREDIT_W(CREDIT_W)) bus_z ();

    credit_loop_controller_mc #(
        .NUM_CH(NUM_CH), .MAX_CREDITS(MAX_CREDITS), .INIT_CREDITS(INIT_CREDITS), .CREDIT_W(CREDIT_W)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .bus(bus)
    );

    // Second build with zero initial credits: only its reset state is of interest.
    credit_loop_controller_mc #(
        .NUM_CH(NUM_CH), .MAX_CREDITS(MAX_CREDITS), .INIT_CREDITS(0), .CREDIT_W(CREDIT_W)
    ) dut_z (
        .i_clk(i_clk), .i_rst(i_rst), .bus(bus_z)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int npulse0  = 0;
    int mark;

    int exp_q0[$];
    int exp_q1[$];

    int m_av  [NUM_CH];
    int m_pd  [NUM_CH];
    bit m_ovf [NUM_CH];
    bit m_udf [NUM_CH];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    function automatic logic [CREDIT_W-1:0] avail_of(input int c);
        return bus.o_avail_credits[c*CREDIT_W +: CREDIT_W];
    endfunction

    function automatic logic [CREDIT_W-1:0] pend_of(input int c);
        return bus.o_pending_credits[c*CREDIT_W +: CREDIT_W];
    endfunction

    // Advance one clock and compare every output against the scoreboard and model.
    task automatic tick();
        @(posedge i_clk);
        #1;
        cycle++;
        if (exp_q0.size() != 0 && exp_q0[0] == cycle) begin
            void'(exp_q0.pop_front());
            check("pulse0", bus.o_pl_cfg_crd[0], 1);
        end else begin
            check("no_pulse0", bus.o_pl_cfg_crd[0], 0);
        end
        if (exp_q1.size() != 0 && exp_q1[0] == cycle) begin
            void'(exp_q1.pop_front());
            check("pulse1", bus.o_pl_cfg_crd[1], 1);
        end else begin
            check("no_pulse1", bus.o_pl_cfg_crd[1], 0);
        end
        if (bus.o_pl_cfg_crd[0] === 1'b1) npulse0++;
        for (int c = 0; c < NUM_CH; c++) begin
            check($sformatf("avail_bound%0d", c), 32'(avail_of(c) <= CREDIT_W'(MAX_CREDITS)), 1);
            check($sformatf("avail%0d", c), avail_of(c), m_av[c]);
            check($sformatf("pending%0d", c), pend_of(c), m_pd[c]);
            check($sformatf("full%0d", c), bus.o_adapter_is_full[c], 32'(m_av[c] == 0));
            check($sformatf("ovf%0d", c), bus.o_ovf_err[c], m_ovf[c]);
            check($sformatf("udf%0d", c), bus.o_udf_err[c], m_udf[c]);
        end
    endtask

    // Drive one cycle of stimulus, record what it should produce, then clock it in.
    task automatic step(input logic rst, input logic [1:0] rd, input logic [1:0] hold,
                        input logic [1:0] lp, input logic [1:0] vld, input logic clr);
        bit iss;
        i_rst                        = rst;
        bus.i_tx_fifo_read_en        = rd;
        bus.i_crd_hold               = hold;
        bus.i_lp_cfg_crd             = lp;
        bus.i_rising_edge_pl_cfg_vld = vld;
        bus.i_err_clr                = clr;
        if (rst) begin
            exp_q0.delete();
            exp_q1.delete();
        end
        for (int c = 0; c < NUM_CH; c++) begin
            if (rst) begin
                m_av[c]  = INIT_CREDITS;
                m_pd[c]  = 0;
                m_ovf[c] = 1'b0;
                m_udf[c] = 1'b0;
            end else begin
                if (clr) begin
                    m_ovf[c] = 1'b0;
                    m_udf[c] = 1'b0;
                end
                // A credit leaves whenever one is owed (queued or just read) and hold is low.
                iss = !hold[c] && (m_pd[c] > 0 || rd[c]);
                if (iss) begin
                    if (c == 0) exp_q0.push_back(cycle + 1);
                    else        exp_q1.push_back(cycle + 1);
                end
                if (rd[c] && !iss) begin
                    if (m_pd[c] == MAX_CREDITS) m_ovf[c] = 1'b1;
                    else                        m_pd[c]++;
                end else if (!rd[c] && iss) begin
                    m_pd[c]--;
                end
                if (lp[c] && !vld[c]) begin
                    if (m_av[c] == MAX_CREDITS) m_ovf[c] = 1'b1;
                    else                        m_av[c]++;
                end else if (vld[c] && !lp[c]) begin
                    if (m_av[c] == 0) m_udf[c] = 1'b1;
                    else              m_av[c]--;
                end
            end
        end
        tick();
    endtask

    initial begin
        bus_z.i_tx_fifo_read_en        = '0;
        bus_z.i_crd_hold               = '0;
        bus_z.i_lp_cfg_crd             = '0;
        bus_z.i_rising_edge_pl_cfg_vld = '0;
        bus_z.i_err_clr                = 1'b0;

        // Reset state for both builds.
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        check("rst_avail0", avail_of(0), 32);
        check("rst_avail1", avail_of(1), 32);
        check("rst_full", bus.o_adapter_is_full, 2'b00);
        check("rst_pending", bus.o_pending_credits, 0);
        check("rst_errs", {bus.o_ovf_err, bus.o_udf_err}, 0);
        check("rst_zero_full", bus_z.o_adapter_is_full, 2'b11);
        check("rst_zero_avail", bus_z.o_avail_credits, 0);

        // Ch0: four isolated reads, each returns one single-cycle pulse one cycle later.
        mark = npulse0;
        for (int k = 0; k < 4; k++) begin
            step(0, 2'b01, 2'b00, 2'b00, 2'b00, 0);
            step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
            step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        end
        check("isolated_pulses", npulse0 - mark, 4);

        // Ch0: hold while five reads arrive, then release and drain five back-to-back pulses.
        for (int k = 0; k < 5; k++) step(0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        check("held_pending", pend_of(0), 5);
        mark = npulse0;
        for (int k = 0; k < 7; k++) step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        check("drain_pulses", npulse0 - mark, 5);
        check("drained_pending", pend_of(0), 0);

        // Ch1: consume everything, then underflow, replenish, and clear the sticky flag.
        for (int k = 0; k < 32; k++) step(0, 2'b00, 2'b00, 2'b00, 2'b10, 0);
        check("ch1_empty", avail_of(1), 0);
        check("ch1_full", bus.o_adapter_is_full[1], 1);
        step(0, 2'b00, 2'b00, 2'b00, 2'b10, 0);
        check("ch1_sat0", avail_of(1), 0);
        check("ch1_udf", bus.o_udf_err[1], 1);
        step(0, 2'b00, 2'b00, 2'b10, 2'b00, 0);
        check("ch1_refill", avail_of(1), 1);
        check("ch1_not_full", bus.o_adapter_is_full[1], 0);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        check("ch1_udf_clr", bus.o_udf_err[1], 0);

        // Clear and a new underflow in the same cycle: the flag stays set.
        step(0, 2'b00, 2'b00, 2'b00, 2'b10, 0);
        step(0, 2'b00, 2'b00, 2'b00, 2'b10, 1);
        check("set_wins", bus.o_udf_err[1], 1);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 1);
        check("udf_clr2", bus.o_udf_err[1], 0);

        // Ch0 at the ceiling: replenish plus consume is neutral, replenish alone overflows.
        step(0, 2'b00, 2'b00, 2'b01, 2'b01, 0);
        check("ch0_neutral", avail_of(0), 32);
        check("ch0_no_ovf", bus.o_ovf_err[0], 0);
        step(0, 2'b00, 2'b00, 2'b01, 2'b00, 0);
        check("ch0_ceiling", avail_of(0), 32);
        check("ch0_ovf", bus.o_ovf_err[0], 1);

        // Ch1 pending queue saturates at MAX_CREDITS under hold.
        for (int k = 0; k < 33; k++) step(0, 2'b10, 2'b10, 2'b00, 2'b00, 0);
        check("pend_sat", pend_of(1), 32);
        check("pend_ovf", bus.o_ovf_err[1], 1);

        // Reset mid-operation discards queued credits; first pulse possible right after.
        for (int k = 0; k < 3; k++) step(0, 2'b01, 2'b01, 2'b00, 2'b00, 0);
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        check("rst_mid_pending", bus.o_pending_credits, 0);
        check("rst_mid_errs", {bus.o_ovf_err, bus.o_udf_err}, 0);
        mark = npulse0;
        step(0, 2'b01, 2'b00, 2'b00, 2'b00, 0);
        step(0, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        check("post_rst_pulse", npulse0 - mark, 1);

        // Concurrency on ch0: reads every 4 cycles, consumes every 6, one replenish.
        step(1, 2'b00, 2'b00, 2'b00, 2'b00, 0);
        mark = npulse0;
        for (int t = 0; t < 42; t++) begin
            step(0, {1'b0, (t % 4 == 0) && (t < 40)}, 2'b00, {1'b0, t == 10},
                 {1'b0, (t % 6 == 0) && (t < 30)}, 0);
        end
        check("conc_pulses", npulse0 - mark, 10);
        check("conc_avail", avail_of(0), 28);
        check("conc_errs", {bus.o_ovf_err, bus.o_udf_err}, 0);

        check("q0_drained", exp_q0.size(), 0);
        check("q1_drained", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
